// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM-subset pipeline control blocks:
// register address width, SRAM wait FSM encoding, decode mode and EX command codes.
package arm_pipe_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wait_state_e;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] EX_MOV = 4'b0001;
  localparam logic [3:0] EX_MVN = 4'b1001;
  localparam logic [3:0] EX_ADD = 4'b0010;
  localparam logic [3:0] EX_SUB = 4'b0100;
  localparam logic [3:0] EX_AND = 4'b0110;
  localparam logic [3:0] EX_ORR = 4'b0111;
  localparam logic [3:0] EX_EOR = 4'b1000;
  localparam logic [3:0] EX_LDR = 4'b0010;
  localparam logic [3:0] EX_STR = 4'b0010;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline control outputs.
// The hazard controller sits on the slave side; the pipeline/bench drives the master side.
interface pipe_hazard_ctrl_if
  import arm_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                  forward_en;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic                  id_uses_src1;
  logic                  ex_wb_en;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  ex_mem_read;
  logic                  mem_wb_en;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic                  branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  if_freeze;
  logic                  if_flush;
  logic                  id_flush;
  logic                  pipe_freeze;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output forward_en, id_src1, id_src2, id_two_src, id_uses_src1,
           ex_wb_en, ex_dst, ex_mem_read, mem_wb_en, mem_dst,
           branch_taken, mem_req, mem_ready,
    input  if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  forward_en, id_src1, id_src2, id_two_src, id_uses_src1,
           ex_wb_en, ex_dst, ex_mem_read, mem_wb_en, mem_dst,
           branch_taken, mem_req, mem_ready,
    output if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_raw_detect.sv
// Single RAW comparator: an ID source that is actually read matches a
// destination that is actually being written back.
module pipe_raw_detect
  import arm_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  uses_i,
  input  logic [REG_ADDR_W-1:0] dst_i,
  input  logic                  wb_en_i,
  output logic                  match_o
);

  assign match_o = uses_i & wb_en_i & (src_i == dst_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush generation for IF/ID and ID/EX, SRAM wait tracking with timeout,
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_hazard_ctrl_if.slave   bus_if
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  wait_state_e       state_q,   state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q,   stall_d;
  logic [CNT_W-1:0]  flush_q,   flush_d;

  logic raw1_ex, raw2_ex, raw1_mem, raw2_mem;
  logic hazard, abort, mem_stall;
  logic if_freeze, if_flush, id_flush, pipe_freeze;

  pipe_raw_detect u_raw1_ex (
    .src_i(bus_if.id_src1), .uses_i(bus_if.id_uses_src1),
    .dst_i(bus_if.ex_dst),  .wb_en_i(bus_if.ex_wb_en),  .match_o(raw1_ex)
  );
  pipe_raw_detect u_raw2_ex (
    .src_i(bus_if.id_src2), .uses_i(bus_if.id_two_src),
    .dst_i(bus_if.ex_dst),  .wb_en_i(bus_if.ex_wb_en),  .match_o(raw2_ex)
  );
  pipe_raw_detect u_raw1_mem (
    .src_i(bus_if.id_src1), .uses_i(bus_if.id_uses_src1),
    .dst_i(bus_if.mem_dst), .wb_en_i(bus_if.mem_wb_en), .match_o(raw1_mem)
  );
  pipe_raw_detect u_raw2_mem (
    .src_i(bus_if.id_src2), .uses_i(bus_if.id_two_src),
    .dst_i(bus_if.mem_dst), .wb_en_i(bus_if.mem_wb_en), .match_o(raw2_mem)
  );

  // With forwarding only a load in EX cannot be bypassed in time.
  assign hazard = bus_if.forward_en ? (bus_if.ex_mem_read & (raw1_ex | raw2_ex))
                                    : (raw1_ex | raw2_ex | raw1_mem | raw2_mem);

  assign abort     = (state_q == WAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign mem_stall = bus_if.mem_req & ~bus_if.mem_ready & ~abort;

  always_comb begin
    if_freeze   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    pipe_freeze = 1'b0;
    if (rst_i) begin
      pipe_freeze = 1'b0;
    end else if (mem_stall) begin
      pipe_freeze = 1'b1;
    end else if (bus_if.branch_taken) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (hazard) begin
      if_freeze = 1'b1;
      id_flush  = 1'b1;
    end else begin
      pipe_freeze = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (bus_if.mem_req & ~bus_if.mem_ready) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (~bus_if.mem_req | bus_if.mem_ready) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (abort) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase

    stall_d = stall_q;
    flush_d = flush_q;
    if ((if_freeze | pipe_freeze) && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    if (if_flush && !(&flush_q)) begin
      flush_d = flush_q + CNT_W'(1);
    end else begin
      flush_d = flush_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign bus_if.if_freeze   = if_freeze;
  assign bus_if.if_flush    = if_flush;
  assign bus_if.id_flush    = id_flush;
  assign bus_if.pipe_freeze = pipe_freeze;
  assign bus_if.mem_timeout = timeout_q;
  assign bus_if.stall_cnt   = stall_q;
  assign bus_if.flush_cnt   = flush_q;

endmodule
